// File: rtl/self_pkg.sv
// Shared definitions for the player-ship pixel engine: op encodings,
// default geometry/timing values, colours, state type and the x clamp helper.
package self_pkg;

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;
  localparam logic [1:0] OP_FIRE  = 2'b10;

  localparam int SHIP_W_DEF     = 10;
  localparam int SHIP_H_DEF     = 8;
  localparam int SHIP_Y_DEF     = 100;
  localparam int SCREEN_W_DEF   = 160;
  localparam int BULLET_DIV_DEF = 2500000;

  localparam logic [2:0] COLOUR_BLACK  = 3'b000;
  localparam logic [2:0] SHIP_COLOUR   = 3'b010;
  localparam logic [2:0] BULLET_COLOUR = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIP,
    S_DONE,
    S_B_ERASE,
    S_B_DRAW
  } state_t;

  function automatic logic [7:0] clamp_x(input logic [7:0] x_in, input logic [7:0] x_max);
    return (x_in > x_max) ? x_max : x_in;
  endfunction

endpackage

// File: rtl/self_bullet_tick.sv
// Bullet pacing: free-running divider that raises a sticky step request on
// each wrap while a bullet is live. A clear consumes the request; when a clear
// and a wrap coincide the clear wins, so back-to-back ticks fold into one step.
module self_bullet_tick
  import self_pkg::*;
#(
  parameter int DIV = BULLET_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic pending
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] count;
  logic          wrap;

  assign wrap = (count == CW'(DIV - 1));

  // Divider counts 0..DIV-1 continuously, independent of bullet activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  // Step request is set by a wrap only while a bullet exists and held until consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if (wrap && enable) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/self_datapath.sv
// Player-ship pixel engine: rasterises the ship sprite (draw or erase) one
// pixel per cycle and moves a single upward bullet one row per tick step.
// Ship commands always take priority over bullet steps.
module self_datapath
  import self_pkg::*;
#(
  parameter int         SHIP_W        = SHIP_W_DEF,
  parameter int         SHIP_H        = SHIP_H_DEF,
  parameter int         SHIP_Y        = SHIP_Y_DEF,
  parameter int         SCREEN_W      = SCREEN_W_DEF,
  parameter int         BULLET_DIV    = BULLET_DIV_DEF,
  parameter logic [2:0] SHIP_COL      = SHIP_COLOUR,
  parameter logic [2:0] BULLET_COL    = BULLET_COLOUR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       self_enable,
  input  logic [1:0] op,
  input  logic [7:0] x,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done,
  output logic       bullet_live
);

  localparam logic [7:0] X_MAX    = 8'(SCREEN_W - SHIP_W);
  localparam logic [7:0] COL_LAST = 8'(SHIP_W - 1);
  localparam logic [6:0] ROW_LAST = 7'(SHIP_H - 1);
  localparam logic [6:0] TOP_ROW  = 7'(SHIP_Y);
  localparam logic [7:0] BX_OFF   = 8'(SHIP_W / 2);
  localparam logic [6:0] BY_START = 7'(SHIP_Y - 1);

  state_t     state;
  state_t     state_next;
  logic [1:0] op_l;
  logic [7:0] xl;
  logic [7:0] col;
  logic [6:0] row;
  logic [7:0] bx;
  logic [6:0] by;
  logic       pending_step;
  logic       step_clear;
  logic       ship_last;

  assign ship_last = (col == COL_LAST) && (row == ROW_LAST);

  self_bullet_tick #(
    .DIV (BULLET_DIV)
  ) u_tick (
    .clk     (clk),
    .reset   (reset),
    .enable  (bullet_live),
    .clear   (step_clear),
    .pending (pending_step)
  );

  // State register; reset aborts any draw or bullet step immediately.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection and pixel outputs decoded from the current state and counters.
  always_comb begin
    state_next = state;
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    colour     = COLOUR_BLACK;
    plot       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    step_clear = 1'b0;
    case (state)
      S_IDLE: begin
        if (self_enable) begin
          state_next = S_SHIP;
        end else if (pending_step && bullet_live) begin
          state_next = S_B_ERASE;
        end
      end
      S_SHIP: begin
        vga_x  = xl + col;
        vga_y  = TOP_ROW + row;
        colour = (op_l == OP_ERASE) ? COLOUR_BLACK : SHIP_COL;
        plot   = 1'b1;
        busy   = 1'b1;
        if (ship_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_B_ERASE: begin
        vga_x  = bx;
        vga_y  = by;
        colour = COLOUR_BLACK;
        plot   = 1'b1;
        if (by == 7'd0) begin
          step_clear = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_B_DRAW;
        end
      end
      S_B_DRAW: begin
        vga_x      = bx;
        vga_y      = by;
        colour     = BULLET_COL;
        plot       = 1'b1;
        step_clear = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Command latch, raster counters and bullet position, each updated by the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_l        <= OP_DRAW;
      xl          <= 8'd0;
      col         <= 8'd0;
      row         <= 7'd0;
      bx          <= 8'd0;
      by          <= 7'd0;
      bullet_live <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (self_enable) begin
            op_l <= op;
            xl   <= clamp_x(x, X_MAX);
            col  <= 8'd0;
            row  <= 7'd0;
          end
        end
        S_SHIP: begin
          if (col == COL_LAST) begin
            col <= 8'd0;
            row <= row + 7'd1;
          end else begin
            col <= col + 8'd1;
          end
        end
        S_DONE: begin
          if ((op_l == OP_FIRE) && !bullet_live) begin
            bullet_live <= 1'b1;
            bx          <= xl + BX_OFF;
            by          <= BY_START;
          end
        end
        S_B_ERASE: begin
          if (by == 7'd0) begin
            bullet_live <= 1'b0;
          end else begin
            by <= by - 7'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
